instr_fetch_unit: RTL and testbench

Fetch-stage PC sequencer and instruction queue placed directly upstream of the instruction memory controller. It drives `pc` and `next_pc` into the memory controller and collects the returned instruction words. Each returned word is stored with its PC in a 2-entry queue. The queue feeds decode through a valid/ready handshake. The block also handles redirects from execute (branch, jump, trap) by flushing the queue and discarding stale responses.

---
 rtl/instr_fetch_unit_pkg.sv | 17 +
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit_fetch_queue.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 90 +++++++++
 tb/tb_instr_fetch_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the fetch-stage PC sequencer and its instruction queue.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_WIDTH  = 32;
  localparam int unsigned IFU_INSTR_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC    = 32'h0000_0000;

  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned QCNT_WIDTH  = 2;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: memory-controller side, execute redirect, and decode handshake.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IFU_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = IFU_INSTR_WIDTH
);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  next_pc;
  logic [INSTR_WIDTH-1:0] instr_read_data;
  logic                   instr_read_data_valid;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   if_valid;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0]  if_pc;
  logic                   id_ready;

  modport master (
    output pc, next_pc, if_valid, if_instr, if_pc,
    input  instr_read_data, instr_read_data_valid, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  pc, next_pc, if_valid, if_instr, if_pc,
    output instr_read_data, instr_read_data_valid, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Two-entry FIFO of {pc, instr} with flush; push and pop may coincide at any occupancy.
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IFU_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = IFU_INSTR_WIDTH
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  push_pc,
  input  logic [INSTR_WIDTH-1:0] push_instr,
  output logic [QCNT_WIDTH-1:0]  count,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_WIDTH-1:0]  head_pc,
  output logic [INSTR_WIDTH-1:0] head_instr
);

  logic [ADDR_WIDTH-1:0]  pc_mem    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic                   rd_ptr;
  logic                   wr_ptr_c;
  logic                   do_push_c;
  logic                   do_pop_c;

  assign empty      = (count == '0);
  assign full       = (count == QCNT_WIDTH'(QUEUE_DEPTH));
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Tail slot: head when count is 0 or 2 (at 2 the head is being popped), else the other slot.
  assign wr_ptr_c  = rd_ptr ^ count[0];
  assign do_pop_c  = pop & ~empty;
  assign do_push_c = push & (~full | do_pop_c);

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= 1'b0;
    end else begin
      if (do_push_c) begin
        pc_mem[wr_ptr_c]    <= push_pc;
        instr_mem[wr_ptr_c] <= push_instr;
      end
      if (do_pop_c) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + QCNT_WIDTH'(do_push_c) - QCNT_WIDTH'(do_pop_c);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch-stage PC sequencer: boot/run/drain FSM, PC register, next_pc mux and queue accept logic.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = IFU_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH = IFU_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(IFU_RESET_PC)
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rstn,
  instr_fetch_unit_if.master   bus
);

  fetch_state_e           state_q;
  fetch_state_e           state_d;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0]  next_pc_c;
  logic [ADDR_WIDTH-1:0]  redirect_target_c;
  logic                   accept_c;
  logic                   pop_c;
  logic [QCNT_WIDTH-1:0]  q_count;
  logic                   q_full;
  logic                   q_empty;
  logic                   unused_redirect_lsb;

  assign redirect_target_c   = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // A redirect flushes the queue, so a same-cycle pop must not be applied.
  assign pop_c = ~q_empty & bus.id_ready & ~bus.redirect_valid;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc_c;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    next_pc_c = pc_q;
    unique case (state_q)
      FETCH_BOOT: state_d = FETCH_RUN;
      FETCH_RUN: begin
        if (bus.redirect_valid) begin
          state_d = FETCH_DRAIN;
        end else begin
          accept_c = bus.instr_read_data_valid & (~q_full | (~q_empty & bus.id_ready));
        end
      end
      // Response arriving here belongs to the pre-redirect PC and is dropped.
      FETCH_DRAIN: state_d = bus.redirect_valid ? FETCH_DRAIN : FETCH_RUN;
      default:     state_d = FETCH_BOOT;
    endcase
    if (!cpu_rstn) begin
      next_pc_c = RESET_PC;
    end else if (bus.redirect_valid) begin
      next_pc_c = redirect_target_c;
    end else if (accept_c) begin
      next_pc_c = pc_q + ADDR_WIDTH'(4);
    end
  end

  fetch_queue #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_fetch_queue (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .push       (accept_c),
    .pop        (pop_c),
    .flush      (bus.redirect_valid),
    .push_pc    (pc_q),
    .push_instr (bus.instr_read_data),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty),
    .head_pc    (bus.if_pc),
    .head_instr (bus.if_instr)
  );

  assign bus.pc       = pc_q;
  assign bus.next_pc  = next_pc_c;
  assign bus.if_valid = ~q_empty;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit against a queue-based behavioural model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic cpu_clk;
  logic cpu_rstn;

  instr_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  instr_fetch_unit #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (RST_PC)
  ) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int unsigned n_checks;
  int unsigned n_fail;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_first;
  bit          m_prev_redir;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc         = RST_PC;
    m_first      = 1'b1;
    m_prev_redir = 1'b0;
  endtask

  // One clock cycle; entered just after a falling edge, returns just after the next one.
  task automatic step(input bit v, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit          acc;
    bit          pop;
    logic [31:0] exp_next;
    chk("pc", bus.pc, m_pc);
    chk("if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("if_pc", bus.if_pc, mq[0].pc);
      chk("if_instr", bus.if_instr, mq[0].instr);
    end
    bus.instr_read_data_valid = v;
    bus.instr_read_data       = mem_word(m_pc);
    bus.id_ready              = rdy;
    bus.redirect_valid        = rv;
    bus.redirect_pc           = rpc;
    acc = !m_first && !m_prev_redir && v && !rv &&
          (mq.size() < 2 || (mq.size() > 0 && rdy));
    pop = (mq.size() > 0) && rdy && !rv;
    if (rv)       exp_next = rpc & 32'hFFFF_FFFC;
    else if (acc) exp_next = m_pc + 32'd4;
    else          exp_next = m_pc;
    #1;
    chk("next_pc", bus.next_pc, exp_next);
    @(posedge cpu_clk);
    if (rv) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
    end
    m_pc         = exp_next;
    m_first      = 1'b0;
    m_prev_redir = rv;
    @(negedge cpu_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"}, bus.pc, RST_PC);
    chk({tag, "_next_pc"}, bus.next_pc, RST_PC);
    chk({tag, "_if_valid"}, 32'(bus.if_valid), 32'd0);
    chk({tag, "_if_instr"}, bus.if_instr, 32'd0);
    chk({tag, "_if_pc"}, bus.if_pc, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cpu_rstn = 1'b0;
    bus.instr_read_data_valid = 1'b1;
    bus.instr_read_data       = '0;
    bus.id_ready              = 1'b0;
    bus.redirect_valid        = 1'b0;
    bus.redirect_pc           = '0;
    repeat (3) @(negedge cpu_clk);
    check_reset_outputs("rst");
    cpu_rstn = 1'b1;
    model_reset();

    // Boot, fill under backpressure, then release decode
    repeat (4) step(1, 0, 0, 32'h0);
    repeat (4) step(1, 1, 0, 32'h0);

    // Redirect with a full queue to a misaligned target
    repeat (3) step(1, 0, 0, 32'h0);
    step(1, 0, 1, 32'h0000_2003);
    repeat (4) step(1, 1, 0, 32'h0);

    // Back-to-back redirects
    step(1, 1, 1, 32'h0000_0040);
    step(1, 1, 1, 32'h0000_0080);
    repeat (4) step(1, 1, 0, 32'h0);

    // Address wrap
    step(1, 1, 1, 32'hFFFF_FFFC);
    repeat (4) step(1, 1, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, $urandom);
    end

    // Asynchronous reset between edges with a full queue
    step(1, 1, 1, 32'h0000_0500);
    repeat (4) step(1, 0, 0, 32'h0);
    chk("full_before_rst", 32'(mq.size()), 32'd2);
    #2;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    cpu_rstn = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge cpu_clk);
    bus.redirect_valid = 1'b0;
    cpu_rstn = 1'b1;
    model_reset();
    repeat (6) step(1, 1, 0, 32'h0);
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
